// File: rtl/accum_addsub_param.sv
// Registered signed add/subtract accumulator with generic width,
// optional saturation, synchronous clear, sample enable and sticky overflow.
// Two stages: operand capture, then accumulate into the running result.
module accum_addsub_param #(
  parameter int WIDTH  = 8,
  parameter bit SAT_EN = 1'b0
) (
  input  logic             i_clk,
  input  logic             ni_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_a,
  input  logic             add_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_ovf_sticky,
  output logic             o_sat
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic             sub;
    logic [WIDTH-1:0] a;
  } op_t;

  op_t              op_q;
  logic [1:1]       vld_pipe;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_w;
  logic             ovf_w;
  logic             sat_w;
  logic [WIDTH-1:0] res_nxt;

  // Effective addition in WIDTH+1 bits; subtraction as ~b + 1 so the top
  // bit is carry for add and no-borrow for subtract.
  always_comb begin
    b_eff   = op_q.sub ? ~op_q.a : op_q.a;
    sum_w   = {1'b0, o_sum} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_q.sub};
    ovf_w   = (o_sum[WIDTH-1] == b_eff[WIDTH-1]) &&
              (sum_w[WIDTH-1] != o_sum[WIDTH-1]);
    sat_w   = SAT_EN & ovf_w;
    res_nxt = sum_w[WIDTH-1:0];
    // Overflow direction follows the common operand sign.
    if (sat_w) res_nxt = o_sum[WIDTH-1] ? SMIN : SMAX;
  end

  // Stage 1: capture operand and mode when enabled; valid tracks enable.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      op_q        <= '0;
      vld_pipe[1] <= 1'b0;
    end else if (i_clr) begin
      op_q        <= '0;
      vld_pipe[1] <= 1'b0;
    end else begin
      vld_pipe[1] <= i_en;
      if (i_en) op_q <= '{sub: add_sub, a: i_a};
    end
  end

  // Stage 2: accumulate and update flags only for a valid operand.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      o_sum        <= '0;
      o_carry      <= 1'b0;
      o_ovf        <= 1'b0;
      o_ovf_sticky <= 1'b0;
      o_sat        <= 1'b0;
    end else if (i_clr) begin
      o_sum        <= '0;
      o_carry      <= 1'b0;
      o_ovf        <= 1'b0;
      o_ovf_sticky <= 1'b0;
      o_sat        <= 1'b0;
    end else if (vld_pipe[1]) begin
      o_sum        <= res_nxt;
      o_carry      <= sum_w[WIDTH];
      o_ovf        <= ovf_w;
      o_ovf_sticky <= o_ovf_sticky | ovf_w;
      o_sat        <= sat_w;
    end
  end

endmodule

// File: tb/tb_accum_addsub_param.sv
module tb_accum_addsub_param;

  logic        clk = 1'b0;
  logic        ni_rst, en, clr, add_sub;
  logic [15:0] a16;
  logic [7:0]  a8;

  logic [7:0]  w8_sum,  s8_sum;
  logic [15:0] w16_sum, s16_sum;
  logic        w8_c, w8_o, w8_st, w8_sat;
  logic        s8_c, s8_o, s8_st, s8_sat;
  logic        w16_c, w16_o, w16_st, w16_sat;
  logic        s16_c, s16_o, s16_st, s16_sat;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  accum_addsub_param #(.WIDTH(8), .SAT_EN(1'b0)) u_w8 (
    .i_clk(clk), .ni_rst(ni_rst), .i_en(en), .i_clr(clr), .i_a(a8), .add_sub(add_sub),
    .o_sum(w8_sum), .o_carry(w8_c), .o_ovf(w8_o), .o_ovf_sticky(w8_st), .o_sat(w8_sat));
  accum_addsub_param #(.WIDTH(8), .SAT_EN(1'b1)) u_s8 (
    .i_clk(clk), .ni_rst(ni_rst), .i_en(en), .i_clr(clr), .i_a(a8), .add_sub(add_sub),
    .o_sum(s8_sum), .o_carry(s8_c), .o_ovf(s8_o), .o_ovf_sticky(s8_st), .o_sat(s8_sat));
  accum_addsub_param #(.WIDTH(16), .SAT_EN(1'b0)) u_w16 (
    .i_clk(clk), .ni_rst(ni_rst), .i_en(en), .i_clr(clr), .i_a(a16), .add_sub(add_sub),
    .o_sum(w16_sum), .o_carry(w16_c), .o_ovf(w16_o), .o_ovf_sticky(w16_st), .o_sat(w16_sat));
  accum_addsub_param #(.WIDTH(16), .SAT_EN(1'b1)) u_s16 (
    .i_clk(clk), .ni_rst(ni_rst), .i_en(en), .i_clr(clr), .i_a(a16), .add_sub(add_sub),
    .o_sum(s16_sum), .o_carry(s16_c), .o_ovf(s16_o), .o_ovf_sticky(s16_st), .o_sat(s16_sat));

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int a, input logic sub);
    a16     = 16'(a);
    a8      = 8'(a);
    add_sub = sub;
    en      = 1'b1;
    step();
  endtask

  task automatic pulse_clr(input int a);
    clr = 1'b1;
    en  = 1'b1;
    a16 = 16'(a);
    a8  = 8'(a);
    step();
    clr = 1'b0;
  endtask

  initial begin
    ni_rst = 1'b0; en = 1'b0; clr = 1'b0; add_sub = 1'b0; a16 = '0; a8 = '0;
    #12;
    chk("rst_sum",    $signed(w8_sum), 0);
    chk("rst_flags",  int'({w8_c, w8_o, w8_st, w8_sat}), 0);
    chk("rst_sflags", int'({s8_c, s8_o, s8_st, s8_sat}), 0);
    ni_rst = 1'b1;

    // Plain add, wrap mode
    feed(17, 0);   chk("add_lat0", $signed(w8_sum), 0);
    feed(75, 0);   chk("add_17",   $signed(w8_sum), 17);
                   chk("add_c0",   int'(w8_c), 0);
    feed(-63, 0);  chk("add_92",   $signed(w8_sum), 92);
    feed(-36, 0);  chk("add_29",   $signed(w8_sum), 29);
                   chk("add_c1",   int'(w8_c), 1);
    feed(0, 0);    chk("add_m7",   $signed(w8_sum), -7);
                   chk("add_ovf0", int'(w8_o), 0);
    feed(0, 0);    chk("add_m7b",  $signed(w8_sum), -7);
                   chk("add_st0",  int'(w8_st), 0);

    // Positive overflow wrap
    pulse_clr(55); chk("clr_sum",  $signed(w8_sum), 0);
    feed(93, 0);   chk("clr_disc", $signed(w8_sum), 0);
    feed(93, 0);   chk("wrap_93",  $signed(w8_sum), 93);
    feed(0, 0);    chk("wrap_m70", $signed(w8_sum), -70);
                   chk("wrap_ovf", int'(w8_o), 1);
                   chk("wrap_st",  int'(w8_st), 1);
                   chk("wrap_c",   int'(w8_c), 0);
    feed(0, 0);    chk("wrap_hold",$signed(w8_sum), -70);
                   chk("wrap_ovf0",int'(w8_o), 0);
                   chk("wrap_st1", int'(w8_st), 1);

    // Enable hold: in-flight 5 lands, then nothing while en=0
    feed(5, 0);
    en = 1'b0; a8 = 8'd99; a16 = 16'd99;
    step();        chk("en_last",  $signed(w8_sum), -65);
    step();        chk("en_hold1", $signed(w8_sum), -65);
    step();        chk("en_hold2", $signed(w8_sum), -65);
                   chk("en_st",    int'(w8_st), 1);
    feed(1, 0);    chk("en_no99",  $signed(w8_sum), -65);
    feed(0, 0);    chk("en_p1",    $signed(w8_sum), -64);

    // Clear after overflow discards the operand on the clear edge
    pulse_clr(50); chk("clr2_sum", $signed(w8_sum), 0);
                   chk("clr2_st",  int'(w8_st), 0);
                   chk("clr2_ovf", int'(w8_o), 0);
    en = 1'b0;
    step();        chk("clr2_no50",$signed(w8_sum), 0);
    feed(3, 0);    chk("clr2_lat", $signed(w8_sum), 0);
    feed(0, 0);    chk("clr2_3",   $signed(w8_sum), 3);

    // Saturation, subtract mode
    en = 1'b0;
    #2 ni_rst = 1'b0;
    #2 ni_rst = 1'b1;
    feed(-63, 1);
    feed(75, 1);   chk("sat_63",   $signed(s8_sum), 63);
    feed(75, 1);   chk("sat_m12",  $signed(s8_sum), -12);
    feed(0, 0);    chk("sat_m87",  $signed(s8_sum), -87);
                   chk("sat_ovf0", int'(s8_o), 0);
    pulse_clr(0);
    feed(115, 0);
    feed(-27, 1);  chk("sat_115",  $signed(s8_sum), 115);
    feed(0, 0);    chk("sat_127",  $signed(s8_sum), 127);
                   chk("sat_flag", int'(s8_sat), 1);
                   chk("sat_ovf",  int'(s8_o), 1);
                   chk("sat_c",    int'(s8_c), 0);
                   chk("wr_m114",  $signed(w8_sum), -114);
                   chk("wr_ovf",   int'(w8_o), 1);
                   chk("wr_nosat", int'(w8_sat), 0);
    feed(0, 0);    chk("sat_hold", $signed(s8_sum), 127);
                   chk("sat_clr",  int'(s8_sat), 0);
                   chk("sat_st",   int'(s8_st), 1);

    // Negative saturation, add mode
    pulse_clr(0);
    feed(-37, 0);
    feed(-37, 0);  chk("neg_m37",  $signed(s8_sum), -37);
    feed(-37, 0);  chk("neg_m74",  $signed(s8_sum), -74);
    feed(-37, 0);  chk("neg_m111", $signed(s8_sum), -111);
    feed(-37, 0);  chk("neg_m128", $signed(s8_sum), -128);
                   chk("neg_sat",  int'(s8_sat), 1);
                   chk("neg_ovf",  int'(s8_o), 1);
                   chk("neg_wr",   $signed(w8_sum), 108);
    feed(0, 0);    chk("neg_m128b",$signed(s8_sum), -128);
                   chk("neg_sat2", int'(s8_sat), 1);
    feed(0, 0);    chk("neg_sat0", int'(s8_sat), 0);

    // Subtracting the most negative value overflows
    pulse_clr(0);
    feed(-128, 1);
    feed(0, 0);    chk("min_wr",   $signed(w8_sum), -128);
                   chk("min_ovf",  int'(w8_o), 1);
                   chk("min_sat",  $signed(s8_sum), 127);

    // Async reset between edges, with an operand in flight
    feed(-37, 0);
    #2 ni_rst = 1'b0;
    #1;
    chk("arst_sum",   $signed(s8_sum), 0);
    chk("arst_flags", int'({s8_c, s8_o, s8_st, s8_sat}), 0);
    chk("arst_wsum",  $signed(w8_sum), 0);
    en = 1'b0;
    #1 ni_rst = 1'b1;
    step();        chk("arst_drop",$signed(s8_sum), 0);

    // WIDTH=16
    pulse_clr(0);
    feed(30000, 0);
    feed(30000, 0); chk("w16_30k", $signed(w16_sum), 30000);
    feed(0, 0);     chk("w16_wrap", $signed(w16_sum), -5536);
                    chk("w16_ovf",  int'(w16_o), 1);
                    chk("s16_sat",  $signed(s16_sum), 32767);
                    chk("s16_flag", int'(s16_sat), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/accum_addsub_param.md
Name: accum_addsub_param

Overview:
- Parametrised successor to the team's 8-bit add/subtract-itself accumulator.
- Registered signed accumulator: each enabled cycle it adds or subtracts the registered input to or from its running result.
- New over the previous block: generic width, optional saturation mode, synchronous clear, sample-enable, and sticky overflow flags.
- Sits in the experiment datapath as a running-sum/difference engine, observed by the bench and status logic.

Parameters:
- WIDTH, 8, data width in bits (signed two's complement), legal range 4..32.
- SAT_EN, 0, 1 = saturate on overflow; 0 = wrap modulo 2^WIDTH.

Ports:
- i_clk  in  1  clock, rising edge.
- ni_rst  in  1  asynchronous active-low reset.
- i_en  in  1  sample/accumulate enable.
- i_clr  in  1  synchronous clear of accumulator and sticky flags.
- i_a  in  WIDTH  signed operand.
- add_sub  in  1  0 = result + a; 1 = result - a.
- o_sum  out  WIDTH  signed accumulator value.
- o_carry  out  1  carry-out (add) or no-borrow (sub) of the last accumulate.
- o_ovf  out  1  signed overflow of the last accumulate.
- o_ovf_sticky  out  1  set on any overflow; cleared only by reset or i_clr.
- o_sat  out  1  last accumulate was saturated (SAT_EN=1 only; otherwise constant 0).

Behaviour:
- Reset (ni_rst=0, asynchronous): o_sum=0, o_carry=0, o_ovf=0, o_ovf_sticky=0, o_sat=0, operand register=0, add_sub register=0.
- Pipeline stage 1, edge N with i_en=1: register i_a and add_sub into an operand register.
- Pipeline stage 2, edge N+1: result <= result ± operand register.
- Latency: i_a sampled at edge N appears in o_sum after edge N+1.
  - First input after reset sees result=0: o_sum = 0 ± a.
- Pipeline valid bit: set when i_en=1, cleared when i_en=0.
  - Stage 2 updates result and flags only when the valid bit is 1.
  - When the valid bit is 0, result and all flags hold.
- Arithmetic:
  - Computed in WIDTH+1 bits as result + (add_sub ? ~b : b) + add_sub, where b is the operand register.
  - o_carry = bit WIDTH of that sum.
  - o_ovf = 1 when both operands of the effective addition have the same sign and the sum's sign differs from it.
- SAT_EN=1 with overflow:
  - Positive overflow: result <= 2^(WIDTH-1)-1.
  - Negative overflow: result <= -2^(WIDTH-1).
  - o_sat=1; o_ovf still 1.
- SAT_EN=0 with overflow: result wraps modulo 2^WIDTH.
- o_ovf_sticky <= o_ovf_sticky | overflow-this-update.
- i_clr=1 (synchronous, highest priority):
  - Next edge: result=0, all flags=0, valid bit=0, operand register=0.
  - i_a on that edge is discarded.
- i_clr deasserted with i_en=1: behaves like the cycle after reset.
- Reset asserted mid-operation: immediate clear regardless of clock, including the in-flight operand.
- add_sub is sampled with i_a, so a per-operand mode change takes effect for that operand only.
- Subtracting -2^(WIDTH-1) is handled by the generic overflow rule.
  - Example: 0 - (-128) overflows; in wrap mode it gives -128 with o_ovf=1.
- All outputs come directly from registers; no combinational path from inputs to outputs.

Test Plan:
- Add, WIDTH=8, SAT_EN=0, i_en=1: feed 17, 75, -63, -36, 0. o_sum sequence one cycle later: 17, 92, 29, -7, -7. o_ovf=0 throughout; o_ovf_sticky=0.
- Positive overflow wrap: feed 93, 93. o_sum = 93, then -70. o_ovf=1 on the second result; o_ovf_sticky stays 1 afterwards. Feeding 0 next keeps -70, o_ovf=0, sticky=1.
- Saturation, SAT_EN=1, subtract mode: feed -63, then 75 twice. o_sum = 63 (0-(-63)), then -12, then -87. Run the 115 then -27 sequence to check the +127 clamp: o_sat=1 on the clamping cycle and o_sum holds 127.
- Negative saturation, SAT_EN=1, add mode: feed -37 five times. o_sum = -37, -74, -111, -128 (o_sat=1, o_ovf=1), -128 (o_sat=1).
- Enable/clear: drop i_en for 3 cycles and o_sum/flags hold. Pulse i_clr after an overflow: o_sum=0 and sticky=0 next edge, and the i_a on the clear edge is not accumulated.
- Async reset mid-stream and WIDTH=16 regression: assert ni_rst=0 between edges and all outputs go to 0 immediately. With WIDTH=16, feeding 30000 twice gives -5536 with o_ovf=1 when SAT_EN=0, and 32767 when SAT_EN=1.
